// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending constants: state encoding, coin values, tube codes
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_EJECT    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [7:0] COIN_5      = 8'd5;
    localparam logic [7:0] COIN_10     = 8'd10;
    localparam logic [7:0] COIN_20     = 8'd20;
    localparam logic [7:0] MAX_BALANCE = 8'd99;

    // refill_tube codes share the vending core's coin codes; 2'b00 means no coin
    localparam logic [1:0] TUBE_NONE = 2'b00;
    localparam logic [1:0] TUBE_5    = 2'b01;
    localparam logic [1:0] TUBE_10   = 2'b10;
    localparam logic [1:0] TUBE_20   = 2'b11;

    // eject one-hot bit order: [0]=5, [1]=10, [2]=20
    localparam logic [2:0] EJ_5  = 3'b001;
    localparam logic [2:0] EJ_10 = 3'b010;
    localparam logic [2:0] EJ_20 = 3'b100;

    function automatic logic [7:0] coin_value(input logic [2:0] onehot);
        case (onehot)
            EJ_5:    coin_value = COIN_5;
            EJ_10:   coin_value = COIN_10;
            EJ_20:   coin_value = COIN_20;
            default: coin_value = 8'd0;
        endcase
    endfunction

    // a payable amount fits the machine balance and is whole nickels
    function automatic logic req_is_valid(input logic [7:0] amount);
        req_is_valid = (amount <= MAX_BALANCE) && ((amount % COIN_5) == 8'd0);
    endfunction

endpackage

// File: rtl/change_dispenser_ctrl_if.sv
// rtl/change_dispenser_ctrl_if.sv - change request/result bus between vending core and dispenser
interface change_dispenser_ctrl_if;
    logic       req_valid;
    logic [7:0] req_amount;
    logic       req_ready;
    logic       done;
    logic       reject;
    logic       fault;
    logic [7:0] paid;
    logic [7:0] shortfall;

    modport master (
        output req_valid, req_amount,
        input  req_ready, done, reject, fault, paid, shortfall
    );

    modport slave (
        input  req_valid, req_amount,
        output req_ready, done, reject, fault, paid, shortfall
    );
endinterface

// File: rtl/coin_tube_counter.sv
// rtl/coin_tube_counter.sv - saturating coin inventory counter with decrement and clear
module coin_tube_counter #(
    parameter int DEPTH = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    output logic [3:0] count
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // clear wins over decrement; a coin loaded in the clearing cycle still counts
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? 4'd1 : 4'd0;
        end else if (inc && !dec) begin
            if (count_q < 4'(DEPTH)) begin
                count_d = count_q + 4'd1;
            end
        end else if (dec && !inc) begin
            if (count_q != 4'd0) begin
                count_d = count_q - 4'd1;
            end
        end
    end

    // inventory register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/change_dispenser_ctrl.sv
// rtl/change_dispenser_ctrl.sv - greedy 20/10/5 coin-return sequencer; CHG_DISP_LOW_ALARM_EN adds low_change
module change_dispenser_ctrl
    import vend_pkg::*;
#(
    parameter int TUBE_DEPTH   = 15,
    parameter int PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    change_dispenser_ctrl_if.slave  bus,
    input  logic                    refill,
    input  logic [1:0]              refill_tube,
    output logic [2:0]              eject,
    input  logic                    eject_ack,
    output logic [3:0]              cnt5,
    output logic [3:0]              cnt10,
    output logic [3:0]              cnt20,
    output logic [2:0]              state_out
`ifdef CHG_DISP_LOW_ALARM_EN
    ,
    output logic                    low_change
`endif
);

    localparam int PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t               state_q, state_d;
    logic [7:0]           remaining_q, remaining_d;
    logic [7:0]           paid_q, paid_d;
    logic [7:0]           shortfall_q, shortfall_d;
    logic                 fault_q, fault_d;
    logic                 reject_q, reject_d;
    logic [2:0]           sel_q, sel_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;
    logic [ACK_W-1:0]     ack_cnt_q, ack_cnt_d;

    logic                 ack_hit;
    logic                 ack_timeout;

    // an ack in the last allowed cycle still counts as a delivered coin
    assign ack_hit     = (state_q == ST_WAIT_ACK) && eject_ack;
    assign ack_timeout = (state_q == ST_WAIT_ACK) && !eject_ack &&
                         (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1));

    // next-state and datapath updates for the dispense sequence
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        paid_d      = paid_q;
        shortfall_d = shortfall_q;
        fault_d     = fault_q;
        reject_d    = reject_q;
        sel_d       = sel_q;
        pulse_d     = pulse_q;
        ack_cnt_d   = ack_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    paid_d  = 8'd0;
                    fault_d = 1'b0;
                    if (req_is_valid(bus.req_amount)) begin
                        remaining_d = bus.req_amount;
                        shortfall_d = 8'd0;
                        reject_d    = 1'b0;
                        state_d     = ST_SELECT;
                    end else begin
                        remaining_d = 8'd0;
                        shortfall_d = bus.req_amount;
                        reject_d    = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_SELECT: begin
                pulse_d = '0;
                if (remaining_q >= COIN_20 && cnt20 != 4'd0) begin
                    sel_d   = EJ_20;
                    state_d = ST_EJECT;
                end else if (remaining_q >= COIN_10 && cnt10 != 4'd0) begin
                    sel_d   = EJ_10;
                    state_d = ST_EJECT;
                end else if (remaining_q >= COIN_5 && cnt5 != 4'd0) begin
                    sel_d   = EJ_5;
                    state_d = ST_EJECT;
                end else begin
                    // zero when fully paid, otherwise what the tubes could not cover
                    shortfall_d = remaining_q;
                    state_d     = ST_DONE;
                end
            end
            ST_EJECT: begin
                if (pulse_q == PULSE_W'(PULSE_CYCLES - 1)) begin
                    ack_cnt_d = '0;
                    state_d   = ST_WAIT_ACK;
                end else begin
                    pulse_d = pulse_q + PULSE_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (ack_hit) begin
                    remaining_d = remaining_q - coin_value(sel_q);
                    paid_d      = paid_q + coin_value(sel_q);
                    state_d     = ST_SELECT;
                end else if (ack_timeout) begin
                    fault_d     = 1'b1;
                    shortfall_d = remaining_q;
                    state_d     = ST_DONE;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // controller state and transaction result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= 8'd0;
            paid_q      <= 8'd0;
            shortfall_q <= 8'd0;
            fault_q     <= 1'b0;
            reject_q    <= 1'b0;
            sel_q       <= 3'd0;
            pulse_q     <= '0;
            ack_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            paid_q      <= paid_d;
            shortfall_q <= shortfall_d;
            fault_q     <= fault_d;
            reject_q    <= reject_d;
            sel_q       <= sel_d;
            pulse_q     <= pulse_d;
            ack_cnt_q   <= ack_cnt_d;
        end
    end

    coin_tube_counter #(.DEPTH(TUBE_DEPTH)) u_tube_5 (
        .clk   (clk),
        .reset (reset),
        .inc   (refill && refill_tube == TUBE_5),
        .dec   (ack_hit && sel_q[0]),
        .clr   (ack_timeout && sel_q[0]),
        .count (cnt5)
    );

    coin_tube_counter #(.DEPTH(TUBE_DEPTH)) u_tube_10 (
        .clk   (clk),
        .reset (reset),
        .inc   (refill && refill_tube == TUBE_10),
        .dec   (ack_hit && sel_q[1]),
        .clr   (ack_timeout && sel_q[1]),
        .count (cnt10)
    );

    coin_tube_counter #(.DEPTH(TUBE_DEPTH)) u_tube_20 (
        .clk   (clk),
        .reset (reset),
        .inc   (refill && refill_tube == TUBE_20),
        .dec   (ack_hit && sel_q[2]),
        .clr   (ack_timeout && sel_q[2]),
        .count (cnt20)
    );

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.reject    = (state_q == ST_DONE) && reject_q;
    assign bus.fault     = fault_q;
    assign bus.paid      = paid_q;
    assign bus.shortfall = shortfall_q;
    assign eject         = (state_q == ST_EJECT) ? sel_q : 3'd0;
    assign state_out     = state_q;

`ifdef CHG_DISP_LOW_ALARM_EN
    logic low_change_q, low_change_d;

    // warn the operator once any tube is nearly empty
    always_comb begin
        low_change_d = (cnt5 <= 4'd1) || (cnt10 <= 4'd1) || (cnt20 <= 4'd1);
    end

    // registered alarm
    always_ff @(posedge clk) begin
        if (reset) begin
            low_change_q <= 1'b0;
        end else begin
            low_change_q <= low_change_d;
        end
    end

    assign low_change = low_change_q;
`endif

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// tb/tb_change_dispenser_ctrl.sv - directed scoreboard bench for change_dispenser_ctrl
module tb_change_dispenser_ctrl;
    import vend_pkg::*;

    localparam int P = 4;

    typedef struct packed {
        logic [7:0] paid;
        logic [7:0] shortfall;
        logic       fault;
        logic       reject;
    } res_t;

    logic       clk;
    logic       reset;
    logic       refill;
    logic [1:0] refill_tube;
    logic [2:0] eject;
    logic       eject_ack;
    logic       auto_ack;
    logic       man_ack;
    logic [3:0] cnt5, cnt10, cnt20;
    logic [2:0] state_out;

    int   checks = 0;
    int   errors = 0;
    int   ack_mode = 0;
    int   lat;
    res_t exp_q[$];
    logic [2:0] ej_q[$];

    change_dispenser_ctrl_if bus_if ();

    assign eject_ack = auto_ack | man_ack;

    change_dispenser_ctrl #(.TUBE_DEPTH(15), .PULSE_CYCLES(P), .ACK_TIMEOUT(255)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .refill      (refill),
        .refill_tube (refill_tube),
        .eject       (eject),
        .eject_ack   (eject_ack),
        .cnt5        (cnt5),
        .cnt10       (cnt10),
        .cnt20       (cnt20),
        .state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ack responder: mode 0 acks two cycles after the pulse ends, mode 1 in the first WAIT_ACK cycle, else never
    initial begin
        logic [2:0] prev;
        prev = 3'd0;
        auto_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (prev != 3'd0 && eject == 3'd0 && !reset) begin
                if (ack_mode == 1) begin
                    auto_ack = 1'b1;
                    @(negedge clk);
                    auto_ack = 1'b0;
                end else if (ack_mode == 0) begin
                    @(negedge clk);
                    auto_ack = 1'b1;
                    @(negedge clk);
                    auto_ack = 1'b0;
                end
            end
            prev = eject;
        end
    end

    // output monitor: pops expected eject pulses and transaction results
    initial begin
        logic [2:0] prev_ej;
        res_t e;
        logic [2:0] ej;
        prev_ej = 3'd0;
        forever begin
            @(negedge clk);
            if (eject != 3'd0 && prev_ej == 3'd0) begin
                if (ej_q.size() == 0) begin
                    check("unexpected_eject", 32'(eject), 0);
                end else begin
                    ej = ej_q.pop_front();
                    check("eject_seq", 32'(eject), 32'(ej));
                end
            end
            prev_ej = eject;
            if (bus_if.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("paid", 32'(bus_if.paid), 32'(e.paid));
                    check("shortfall", 32'(bus_if.shortfall), 32'(e.shortfall));
                    check("fault", 32'(bus_if.fault), 32'(e.fault));
                    check("reject", 32'(bus_if.reject), 32'(e.reject));
                end
            end
        end
    end

    task automatic load(input logic [1:0] tube, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            refill = 1'b1;
            refill_tube = tube;
        end
        @(negedge clk);
        refill = 1'b0;
        refill_tube = TUBE_NONE;
    endtask

    task automatic wait_done(input int max, inout int l);
        while (!bus_if.done && l < max) begin
            @(negedge clk);
            l++;
        end
        check("done_seen", 32'(bus_if.done), 1);
    endtask

    // lat = cycle index of done counted from the accepting edge c0
    task automatic do_req(input logic [7:0] amt, input int max, output int l);
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_amount = amt;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        l = 1;
        wait_done(max, l);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        refill = 1'b0;
        refill_tube = TUBE_NONE;
        man_ack = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_amount = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(state_out), 0);
        check("rst_ready", 32'(bus_if.req_ready), 1);
        check("rst_eject", 32'(eject), 0);
        check("rst_done", 32'(bus_if.done), 0);
        check("rst_paid", 32'(bus_if.paid), 0);
        check("rst_fault", 32'(bus_if.fault), 0);
        check("rst_cnt", 32'({cnt5, cnt10, cnt20}), 0);

        // 35 from 2/2/2 coins
        load(TUBE_20, 2);
        load(TUBE_10, 2);
        load(TUBE_5, 2);
        ack_mode = 0;
        ej_q.push_back(EJ_20);
        ej_q.push_back(EJ_10);
        ej_q.push_back(EJ_5);
        exp_q.push_back('{paid: 8'd35, shortfall: 8'd0, fault: 1'b0, reject: 1'b0});
        do_req(8'd35, 200, lat);
        check("t1_cnt20", 32'(cnt20), 1);
        check("t1_cnt10", 32'(cnt10), 1);
        check("t1_cnt5", 32'(cnt5), 1);

        // 30 with only one 10 and three 5s: short by 5
        do_reset();
        check("t2_rst_cnt", 32'({cnt5, cnt10, cnt20}), 0);
        load(TUBE_10, 1);
        load(TUBE_5, 3);
        ej_q.push_back(EJ_10);
        for (int i = 0; i < 3; i++) ej_q.push_back(EJ_5);
        exp_q.push_back('{paid: 8'd25, shortfall: 8'd5, fault: 1'b0, reject: 1'b0});
        do_req(8'd30, 300, lat);
        check("t2_cnt5", 32'(cnt5), 0);

        // single coin, ack in first WAIT_ACK cycle
        load(TUBE_5, 1);
        ack_mode = 1;
        ej_q.push_back(EJ_5);
        exp_q.push_back('{paid: 8'd5, shortfall: 8'd0, fault: 1'b0, reject: 1'b0});
        do_req(8'd5, 50, lat);
        check("single_latency", 32'(lat), 32'(4 + P));

        // zero amount
        exp_q.push_back('{paid: 8'd0, shortfall: 8'd0, fault: 1'b0, reject: 1'b0});
        do_req(8'd0, 20, lat);
        check("zero_latency", 32'(lat), 2);

        // jam: no ack ever arrives
        load(TUBE_20, 1);
        ack_mode = 2;
        ej_q.push_back(EJ_20);
        exp_q.push_back('{paid: 8'd0, shortfall: 8'd20, fault: 1'b1, reject: 1'b0});
        do_req(8'd20, 400, lat);
        check("jam_latency", 32'(lat), 32'(2 + P + 255));
        check("jam_cnt20", 32'(cnt20), 0);

        // invalid requests
        exp_q.push_back('{paid: 8'd0, shortfall: 8'd37, fault: 1'b0, reject: 1'b1});
        do_req(8'd37, 20, lat);
        check("rej37_latency", 32'(lat), 1);
        exp_q.push_back('{paid: 8'd0, shortfall: 8'd120, fault: 1'b0, reject: 1'b1});
        do_req(8'd120, 20, lat);
        check("rej120_latency", 32'(lat), 1);
        exp_q.push_back('{paid: 8'd0, shortfall: 8'd100, fault: 1'b0, reject: 1'b1});
        do_req(8'd100, 20, lat);
        check("rej100_latency", 32'(lat), 1);

        // reset during the second EJECT cycle
        load(TUBE_10, 1);
        ej_q.push_back(EJ_10);
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_amount = 8'd10;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_eject", 32'(eject), 32'(EJ_10));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_eject", 32'(eject), 0);
        check("mid_rst_state", 32'(state_out), 0);
        check("mid_rst_cnt", 32'({cnt5, cnt10, cnt20}), 0);
        check("mid_rst_done", 32'(bus_if.done), 0);
        reset = 1'b0;

        // refill and ack on the 20 tube in the same cycle
        load(TUBE_20, 2);
        ej_q.push_back(EJ_20);
        exp_q.push_back('{paid: 8'd20, shortfall: 8'd0, fault: 1'b0, reject: 1'b0});
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_amount = 8'd20;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        lat = 0;
        while (state_out != 3'd3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("reach_wait_ack", 32'(state_out), 3);
        refill = 1'b1;
        refill_tube = TUBE_20;
        man_ack = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        refill_tube = TUBE_NONE;
        man_ack = 1'b0;
        check("simul_cnt20", 32'(cnt20), 2);
        lat = 0;
        wait_done(20, lat);

        repeat (3) @(negedge clk);
        check("eject_q_empty", 32'(ej_q.size()), 0);
        check("result_q_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser_ctrl.md
# change_dispenser_ctrl

Sequences the coin-return hardware after a vending transaction. It accepts a change amount from the vending machine core and dispenses it greedily from three coin tubes (20, 10, 5). It drives one eject solenoid at a time, waits for the coin-drop sensor, and tracks the tube inventories. It sits between the vending FSM's `change` output and the physical ejector/sensor pins.

## Interface
Parameters:
- `TUBE_DEPTH`, 15: maximum coins per tube. Counts saturate here. Must be ≤ 15.
- `PULSE_CYCLES`, 4: width of each eject pulse, in clocks. Must be ≥ 1.
- `ACK_TIMEOUT`, 255: clocks allowed in WAIT_ACK before declaring a jam. Must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  change request present.
- `req_amount`  in  8  change to pay, in units of 1.
- `req_ready`  out  1  high only in IDLE.
- `refill`  in  1  one coin loaded this cycle.
- `refill_tube`  in  2  tube being refilled: 01 = 5, 10 = 10, 11 = 20. Value 00 is ignored.
- `eject`  out  3  one-hot solenoid drive: [0] = 5, [1] = 10, [2] = 20.
- `eject_ack`  in  1  coin-drop sensor. Synchronous, one cycle or longer.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `reject`  out  1  one-cycle pulse, coincident with `done`, for an invalid request.
- `fault`  out  1  eject-acknowledge timeout occurred in the last transaction.
- `paid`  out  8  amount dispensed in the last transaction.
- `shortfall`  out  8  amount left unpaid in the last transaction.
- `cnt5`, `cnt10`, `cnt20`  out  4 each  tube inventories.
- `state_out`  out  3  current state encoding.

## Operation
States: IDLE=0, SELECT=1, EJECT=2, WAIT_ACK=3, DONE=4.

- **IDLE → SELECT** on `req_valid && req_ready`.
  - Loads `remaining = req_amount`.
  - Clears `paid`, `shortfall` and `fault`.
- **Invalid request:** `req_amount > 99` or not a multiple of 5.
  - Goes IDLE → DONE directly.
  - Sets `shortfall = req_amount`, `paid = 0` and `reject = 1`.
  - No eject occurs.
- **SELECT**, one cycle. Picks the largest denomination d such that `remaining ≥ d` and the tube count is > 0.
  - If a denomination is found: go to EJECT.
  - If `remaining == 0`: go to DONE.
  - If `remaining > 0` and no denomination qualifies: go to DONE with `shortfall = remaining`.
- **EJECT.** `eject` is driven one-hot for exactly `PULSE_CYCLES` cycles, then the FSM goes to WAIT_ACK. `eject` is 0 in every other state.
- **WAIT_ACK**, on `eject_ack`:
  - Decrement the tube count.
  - `remaining -= d`, `paid += d`.
  - Go to SELECT.
- **WAIT_ACK timeout.** If `ACK_TIMEOUT` cycles pass without an ack:
  - `fault = 1`.
  - The jammed tube count is forced to 0.
  - `shortfall = remaining`.
  - Go to DONE.
- **DONE:**
  - Pulses `done` (and `reject` if the request was invalid).
  - Returns to IDLE on the next clock.
  - `paid`, `shortfall` and `fault` hold until the next accept.
- **Stray acknowledges.** `eject_ack` outside WAIT_ACK is ignored.
- **Refill** is accepted in any state.
  - The count saturates at `TUBE_DEPTH`.
  - Refill and acknowledge-decrement on the same tube in the same cycle: net count unchanged.
  - Refill and timeout-clear on the same tube in the same cycle: the count becomes 1.
- **Arithmetic:** `remaining`, `paid` and `shortfall` are 8-bit. The greedy check guarantees no underflow.

## Timing
- **Reset values:**
  - All outputs are 0, and `state_out` = IDLE.
  - `req_ready` = 1 in the first cycle after reset deasserts.
  - Tube counts are 0.
- **Reset mid-operation:** `eject` drops at the reset edge. No `done` is produced, and counts return to 0.
- **Single-coin latency with the ack in the first WAIT_ACK cycle:**
  - Accept at edge c0.
  - SELECT in c1.
  - EJECT in c2 to c(1+PULSE_CYCLES).
  - WAIT_ACK in c(2+PULSE_CYCLES).
  - SELECT in c(3+PULSE_CYCLES).
  - `done` in c(4+PULSE_CYCLES).
- **Zero amount:** `done` in cycle c2.
- **Invalid request:** `done` and `reject` in cycle c1.

## Configuration
- **`CHG_DISP_LOW_ALARM_EN` defined:**
  - Adds output `low_change` (1 bit).
  - `low_change` is high whenever any tube count is ≤ 1.
  - It is registered and resets to 0.
- **`CHG_DISP_LOW_ALARM_EN` undefined:** the port and its logic are absent. All other behaviour is identical.

## Structure
- **Shared package** `vend_pkg`:
  - State encoding constants.
  - Denomination constants `COIN_5`, `COIN_10`, `COIN_20`.
  - `MAX_BALANCE = 99`.
  - `refill_tube` codes, which match the vending machine's coin codes.
- **Sub-module** `coin_tube_counter`:
  - Instantiated three times.
  - Inputs: saturating increment, decrement, and clear-to-zero.

## Test plan
1. Refill 2×20, 2×10 and 2×5, then request 35, acking each pulse 2 cycles after it ends → `eject` sequence 100, 010, 001; `paid` = 35, `shortfall` = 0; counts 1/1/1.
2. Refill 0×20, 1×10 and 3×5, then request 30 → ejects 10, 5, 5, 5 in that order; `paid` = 25, `shortfall` = 5, `fault` = 0.
3. Request 0 → `done` in c2, `eject` never asserted, `paid` = 0, `shortfall` = 0.
4. Refill 1×20, request 20, never ack → after `PULSE_CYCLES` + 255 cycles: `fault` = 1, `cnt20` = 0, `paid` = 0, `shortfall` = 20.
5. Request 37, then request 120 → each gives `reject` and `done` in c1, `shortfall` equal to the request, no eject.
6. Refill 1×10, request 10, assert `reset` during the 2nd EJECT cycle → `eject` = 0 and IDLE after the edge, counts 0, no `done`. Simultaneous refill (20) and ack (20) leaves `cnt20` unchanged.
